// File: rtl/sump_cmd_decoder_pkg.sv
//==== sump_pkg | SUMP opcodes, ID word and ID FSM state type | rev 1.0 ====
`default_nettype none

package sump_pkg;

  localparam logic [7:0] CMD_RESET     = 8'h00;
  localparam logic [7:0] CMD_ARM       = 8'h01;
  localparam logic [7:0] CMD_ID        = 8'h02;
  localparam logic [7:0] CMD_XON       = 8'h11;
  localparam logic [7:0] CMD_XOFF      = 8'h13;
  localparam logic [7:0] CMD_DIV       = 8'h80;
  localparam logic [7:0] CMD_CNT       = 8'h81;
  localparam logic [7:0] CMD_FLAGS     = 8'h82;
  localparam logic [7:0] CMD_TRIG_BASE = 8'hC0;

  localparam logic [31:0] ID_WORD_DEFAULT = 32'h534c4131;
  localparam int unsigned ID_WAIT_CYCLES  = 4;

  typedef enum logic [1:0] {
    ID_IDLE = 2'd0,
    ID_REQ  = 2'd1,
    ID_WAIT = 2'd2
  } id_state_e;

  // Trigger opcodes occupy 0xC0..0xCF: bits [3:2] stage, bits [1:0] register.
  function automatic logic is_trig_cmd(input logic [7:0] code);
    return code[7:4] == CMD_TRIG_BASE[7:4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sump_cmd_decoder_if.sv
//==== sump_cmd_decoder_if | command stream in, send/busy handshake out | rev 1.0 ====
`default_nettype none

interface sump_cmd_decoder_if;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        busy;
  logic        send;
  logic [31:0] send_data;
  logic [3:0]  send_valid;

  modport master (
    output cmd_code, cmd_data, cmd_valid, busy,
    input  send, send_data, send_valid
  );

  modport slave (
    input  cmd_code, cmd_data, cmd_valid, busy,
    output send, send_data, send_valid
  );
endinterface

`default_nettype wire

// File: rtl/sump_cmd_decoder_id_responder.sv
//==== sump_id_responder | ID query FSM with send/busy handshake | rev 1.0 ====
`default_nettype none

module sump_id_responder
  import sump_pkg::*;
#(
  parameter logic [31:0] ID_WORD = ID_WORD_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        id_req_i,
  input  wire logic        busy_i,
  output logic             send_o,
  output logic [31:0]      send_data_o,
  output logic [3:0]       send_valid_o
);

  localparam logic [1:0] c_TIMEOUT_LAST = 2'(ID_WAIT_CYCLES - 1);

  id_state_e  state_q, state_d;
  logic [1:0] timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ID_IDLE;
      timer_q <= 2'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ID_IDLE: begin
        timer_d = 2'd0;
        if (id_req_i) state_d = ID_REQ;
      end
      ID_REQ: begin
        timer_d = 2'd0;
        if (!busy_i) state_d = ID_WAIT;
      end
      ID_WAIT: begin
        // Leave once the transmitter picks the word up, or give up after the timeout.
        if (busy_i || timer_q == c_TIMEOUT_LAST) begin
          state_d = ID_IDLE;
          timer_d = 2'd0;
        end else begin
          timer_d = timer_q + 2'd1;
        end
      end
      default: begin
        state_d = ID_IDLE;
        timer_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    send_o       = 1'b0;
    send_data_o  = 32'd0;
    send_valid_o = 4'd0;
    if (state_q == ID_REQ && !busy_i) begin
      send_o       = 1'b1;
      send_data_o  = ID_WORD;
      send_valid_o = 4'hF;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sump_cmd_decoder.sv
//==== sump_cmd_decoder | SUMP command decoder and capture config bank | rev 1.0 ====
`default_nettype none

module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int          NUM_STAGES   = 4,
  parameter logic [31:0] ID_WORD      = ID_WORD_DEFAULT,
  parameter int          RESET_REPEAT = 5
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  sump_cmd_decoder_if.slave            bus,
  output logic                         soft_reset_o,
  output logic                         arm_o,
  output logic                         xoff_o,
  output logic [23:0]                  divider_o,
  output logic [15:0]                  read_count_o,
  output logic [15:0]                  delay_count_o,
  output logic [15:0]                  flags_o,
  output logic [32*NUM_STAGES-1:0]     trig_mask_o,
  output logic [32*NUM_STAGES-1:0]     trig_value_o,
  output logic [32*NUM_STAGES-1:0]     trig_cfg_o
);

  localparam int         c_TW       = 32 * NUM_STAGES;
  localparam logic [2:0] c_RST_LAST = 3'(RESET_REPEAT - 1);

  logic [7:0]  w_code;
  logic [31:0] w_data;
  logic        w_valid, w_soft, w_trig;
  logic [1:0]  w_stage, w_sel;

  logic [2:0]      rst_cnt_q, rst_cnt_d;
  logic            soft_reset_q, soft_reset_d, arm_q, arm_d, xoff_q, xoff_d;
  logic [23:0]     divider_q, divider_d;
  logic [15:0]     read_count_q, read_count_d, delay_count_q, delay_count_d;
  logic [15:0]     flags_q, flags_d;
  logic [c_TW-1:0] trig_mask_q, trig_mask_d, trig_value_q, trig_value_d;
  logic [c_TW-1:0] trig_cfg_q, trig_cfg_d;

  assign w_code  = bus.cmd_code;
  assign w_data  = bus.cmd_data;
  assign w_valid = bus.cmd_valid;
  assign w_stage = w_code[3:2];
  assign w_sel   = w_code[1:0];
  assign w_trig  = w_valid && is_trig_cmd(w_code);
  assign w_soft  = w_valid && (w_code == CMD_RESET) && (rst_cnt_q == c_RST_LAST);

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (w_valid) begin
      if (w_code != CMD_RESET || w_soft) rst_cnt_d = 3'd0;
      else                               rst_cnt_d = rst_cnt_q + 3'd1;
    end
  end

  always_comb begin
    soft_reset_d  = w_soft;
    arm_d         = w_valid && (w_code == CMD_ARM);
    xoff_d        = xoff_q;
    divider_d     = divider_q;
    read_count_d  = read_count_q;
    delay_count_d = delay_count_q;
    flags_d       = flags_q;
    trig_mask_d   = trig_mask_q;
    trig_value_d  = trig_value_q;
    trig_cfg_d    = trig_cfg_q;
    if (w_soft) begin
      xoff_d        = 1'b0;
      divider_d     = 24'd0;
      read_count_d  = 16'd0;
      delay_count_d = 16'd0;
      flags_d       = 16'd0;
      trig_mask_d   = '0;
      trig_value_d  = '0;
      trig_cfg_d    = '0;
    end else if (w_valid) begin
      case (w_code)
        CMD_DIV:   divider_d = w_data[23:0];
        CMD_CNT: begin
          read_count_d  = w_data[15:0];
          delay_count_d = w_data[31:16];
        end
        CMD_FLAGS: flags_d = w_data[15:0];
        CMD_XOFF:  xoff_d  = 1'b1;
        CMD_XON:   xoff_d  = 1'b0;
        default:   ;
      endcase
      // Stages beyond NUM_STAGES never match, so their opcodes fall through silently.
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (w_trig && int'(w_stage) == s) begin
          case (w_sel)
            2'd0:    trig_mask_d[32*s +: 32]  = w_data;
            2'd1:    trig_value_d[32*s +: 32] = w_data;
            2'd2:    trig_cfg_d[32*s +: 32]   = w_data;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt_q     <= 3'd0;
      soft_reset_q  <= 1'b0;
      arm_q         <= 1'b0;
      xoff_q        <= 1'b0;
      divider_q     <= 24'd0;
      read_count_q  <= 16'd0;
      delay_count_q <= 16'd0;
      flags_q       <= 16'd0;
      trig_mask_q   <= '0;
      trig_value_q  <= '0;
      trig_cfg_q    <= '0;
    end else begin
      rst_cnt_q     <= rst_cnt_d;
      soft_reset_q  <= soft_reset_d;
      arm_q         <= arm_d;
      xoff_q        <= xoff_d;
      divider_q     <= divider_d;
      read_count_q  <= read_count_d;
      delay_count_q <= delay_count_d;
      flags_q       <= flags_d;
      trig_mask_q   <= trig_mask_d;
      trig_value_q  <= trig_value_d;
      trig_cfg_q    <= trig_cfg_d;
    end
  end

  assign soft_reset_o  = soft_reset_q;
  assign arm_o         = arm_q;
  assign xoff_o        = xoff_q;
  assign divider_o     = divider_q;
  assign read_count_o  = read_count_q;
  assign delay_count_o = delay_count_q;
  assign flags_o       = flags_q;
  assign trig_mask_o   = trig_mask_q;
  assign trig_value_o  = trig_value_q;
  assign trig_cfg_o    = trig_cfg_q;

  sump_id_responder #(
    .ID_WORD (ID_WORD)
  ) u_id_responder (
    .clk          (clk),
    .rst          (rst),
    .id_req_i     (w_valid && (w_code == CMD_ID)),
    .busy_i       (bus.busy),
    .send_o       (bus.send),
    .send_data_o  (bus.send_data),
    .send_valid_o (bus.send_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_sump_cmd_decoder.sv
//==== tb_sump_cmd_decoder | vector table, corner sequences and random model check | rev 1.0 ====
`default_nettype none

module tb_sump_cmd_decoder;

  localparam int          NS  = 2;
  localparam int          RR  = 5;
  localparam logic [31:0] IDW = 32'h534c4131;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sump_cmd_decoder_if bus();

  logic             soft_reset, arm, xoff;
  logic [23:0]      divider;
  logic [15:0]      read_count, delay_count, flags;
  logic [32*NS-1:0] trig_mask, trig_value, trig_cfg;

  sump_cmd_decoder #(
    .NUM_STAGES   (NS),
    .ID_WORD      (IDW),
    .RESET_REPEAT (RR)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .soft_reset_o  (soft_reset),
    .arm_o         (arm),
    .xoff_o        (xoff),
    .divider_o     (divider),
    .read_count_o  (read_count),
    .delay_count_o (delay_count),
    .flags_o       (flags),
    .trig_mask_o   (trig_mask),
    .trig_value_o  (trig_value),
    .trig_cfg_o    (trig_cfg)
  );

  int checks = 0;
  int errors = 0;
  int n_send = 0;
  int n_soft = 0;
  int n_arm  = 0;

  // Reference model state
  logic [23:0] m_div;
  logic [15:0] m_rcnt, m_dcnt, m_flags;
  logic        m_xoff, m_arm, m_soft;
  logic [31:0] m_mask [NS];
  logic [31:0] m_val  [NS];
  logic [31:0] m_cfg  [NS];
  int          m_zeros;

  always begin
    @(negedge clk);
    #3;
    if (bus.send === 1'b1) n_send++;
    if (soft_reset === 1'b1) n_soft++;
    if (arm === 1'b1) n_arm++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear_cfg();
    m_div = '0; m_rcnt = '0; m_dcnt = '0; m_flags = '0; m_xoff = 1'b0;
    for (int s = 0; s < NS; s++) begin
      m_mask[s] = '0; m_val[s] = '0; m_cfg[s] = '0;
    end
  endtask

  task automatic model_reset();
    model_clear_cfg();
    m_arm = 1'b0; m_soft = 1'b0; m_zeros = 0;
  endtask

  task automatic model_cmd(input int code, input logic [31:0] data);
    int s, k;
    m_arm = 1'b0;
    m_soft = 1'b0;
    if (code == 0) begin
      m_zeros = m_zeros + 1;
      if (m_zeros == RR) begin
        m_soft = 1'b1;
        m_zeros = 0;
        model_clear_cfg();
      end
    end else begin
      m_zeros = 0;
      if (code == 'h01) m_arm = 1'b1;
      if (code == 'h13) m_xoff = 1'b1;
      if (code == 'h11) m_xoff = 1'b0;
      if (code == 'h80) m_div = data[23:0];
      if (code == 'h81) begin m_rcnt = data[15:0]; m_dcnt = data[31:16]; end
      if (code == 'h82) m_flags = data[15:0];
      if (code >= 'hC0 && code <= 'hCF) begin
        s = (code - 'hC0) / 4;
        k = (code - 'hC0) % 4;
        if (s < NS) begin
          if (k == 0) m_mask[s] = data;
          if (k == 1) m_val[s]  = data;
          if (k == 2) m_cfg[s]  = data;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".divider"}, 32'(divider), 32'(m_div));
    chk({tag, ".read_count"}, 32'(read_count), 32'(m_rcnt));
    chk({tag, ".delay_count"}, 32'(delay_count), 32'(m_dcnt));
    chk({tag, ".flags"}, 32'(flags), 32'(m_flags));
    chk({tag, ".xoff"}, 32'(xoff), 32'(m_xoff));
    chk({tag, ".arm"}, 32'(arm), 32'(m_arm));
    chk({tag, ".soft_reset"}, 32'(soft_reset), 32'(m_soft));
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("%s.trig_mask%0d", tag, s), trig_mask[32*s +: 32], m_mask[s]);
      chk($sformatf("%s.trig_value%0d", tag, s), trig_value[32*s +: 32], m_val[s]);
      chk($sformatf("%s.trig_cfg%0d", tag, s), trig_cfg[32*s +: 32], m_cfg[s]);
    end
  endtask

  // Issues one command; returns on the falling edge after it was latched.
  task automatic do_cmd(input logic [7:0] code, input logic [31:0] data);
    @(negedge clk);
    bus.cmd_code  = code;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    model_cmd(int'(code), data);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    m_arm = 1'b0;
    m_soft = 1'b0;
  endtask

  function automatic logic [31:0] fval(input int f);
    case (f)
      0: return 32'(divider);
      1: return 32'(read_count);
      2: return 32'(delay_count);
      3: return 32'(flags);
      4: return 32'(xoff);
      5: return trig_value[31:0];
      6: return trig_value[63:32];
      7: return trig_mask[63:32];
      8: return trig_cfg[31:0];
      9: return 32'(arm);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  typedef struct {
    logic [7:0]  code;
    logic [31:0] data;
    int          field;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int base_send, base_soft, base_arm, r, code;
    logic [31:0] data;

    tbl[0]  = '{8'h80, 32'h00123456, 0, 32'h00123456};
    tbl[1]  = '{8'h81, 32'h00100200, 1, 32'h00000200};
    tbl[2]  = '{8'h81, 32'h00100200, 2, 32'h00000010};
    tbl[3]  = '{8'hC5, 32'hDEADBEEF, 6, 32'hDEADBEEF};
    tbl[4]  = '{8'hC5, 32'hDEADBEEF, 5, 32'h00000000};
    tbl[5]  = '{8'hC4, 32'hA5A5A5A5, 7, 32'hA5A5A5A5};
    tbl[6]  = '{8'hC2, 32'h12345678, 8, 32'h12345678};
    tbl[7]  = '{8'h82, 32'h0000ABCD, 3, 32'h0000ABCD};
    tbl[8]  = '{8'h13, 32'h00000000, 4, 32'h00000001};
    tbl[9]  = '{8'h11, 32'h00000000, 4, 32'h00000000};
    tbl[10] = '{8'hC8, 32'hFFFFFFFF, 7, 32'hA5A5A5A5};
    tbl[11] = '{8'hC9, 32'hFFFFFFFF, 6, 32'hDEADBEEF};
    tbl[12] = '{8'hC7, 32'h0BAD0BAD, 7, 32'hA5A5A5A5};
    tbl[13] = '{8'h01, 32'h00000000, 9, 32'h00000001};
    tbl[14] = '{8'h55, 32'hFFFFFFFF, 0, 32'h00123456};

    // Reset state
    rst = 1'b1;
    bus.cmd_code = 8'h00; bus.cmd_data = 32'd0; bus.cmd_valid = 1'b0; bus.busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.send", 32'(bus.send), 32'd0);
    chk("reset.send_data", bus.send_data, 32'd0);
    chk("reset.send_valid", 32'(bus.send_valid), 32'd0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      do_cmd(tbl[i].code, tbl[i].data);
      chk($sformatf("tbl[%0d]", i), fval(tbl[i].field), tbl[i].exp);
      check_all($sformatf("tbl[%0d]", i));
    end
    idle(1);

    // Five 0x00 commands clear a previously written divider
    do_cmd(8'h80, 32'h00ABCDEF);
    check_all("pre_reset");
    base_soft = n_soft;
    for (int i = 0; i < 5; i++) begin
      do_cmd(8'h00, 32'd0);
      check_all($sformatf("zero%0d", i));
      chk($sformatf("zero%0d.soft", i), 32'(soft_reset), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("soft.divider_cleared", 32'(divider), 32'd0);
    idle(1);
    chk("soft.pulse_end", 32'(soft_reset), 32'd0);
    chk("soft.pulse_count", n_soft - base_soft, 1);

    // Interrupted zero run: no soft reset, one arm
    base_soft = n_soft;
    base_arm  = n_arm;
    for (int i = 0; i < 9; i++) begin
      do_cmd((i == 4) ? 8'h01 : 8'h00, 32'd0);
      check_all($sformatf("interrupt%0d", i));
    end
    idle(2);
    chk("interrupt.soft_count", n_soft - base_soft, 0);
    chk("interrupt.arm_count", n_arm - base_arm, 1);

    // ID with busy low
    base_send = n_send;
    do_cmd(8'h02, 32'd0);
    #1;
    chk("id_low.send", 32'(bus.send), 32'd1);
    chk("id_low.send_data", bus.send_data, IDW);
    chk("id_low.send_valid", 32'(bus.send_valid), 32'hF);
    @(negedge clk);
    #1;
    chk("id_low.send_drop", 32'(bus.send), 32'd0);
    chk("id_low.data_drop", bus.send_data, 32'd0);
    chk("id_low.valid_drop", 32'(bus.send_valid), 32'd0);
    idle(8);
    chk("id_low.send_count", n_send - base_send, 1);

    // ID with busy held; a second 0x02 in REQ is dropped
    base_send = n_send;
    @(negedge clk);
    bus.busy = 1'b1;
    do_cmd(8'h02, 32'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("id_busy%0d.send", i), 32'(bus.send), 32'd0);
      if (i == 4) do_cmd(8'h02, 32'd0);
      else @(negedge clk);
    end
    bus.busy = 1'b0;
    #1;
    chk("id_busy.release_send", 32'(bus.send), 32'd1);
    chk("id_busy.release_data", bus.send_data, IDW);
    @(negedge clk);
    bus.busy = 1'b1;
    #1;
    chk("id_busy.after_send", 32'(bus.send), 32'd0);
    @(negedge clk);
    bus.busy = 1'b0;
    idle(8);
    chk("id_busy.send_count", n_send - base_send, 1);

    // rst while the ID FSM sits in REQ
    do_cmd(8'h80, 32'h00000077);
    base_send = n_send;
    @(negedge clk);
    bus.busy = 1'b1;
    do_cmd(8'h02, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.busy = 1'b0;
    model_reset();
    #1;
    chk("rst_req.send", 32'(bus.send), 32'd0);
    idle(8);
    chk("rst_req.send_count", n_send - base_send, 0);
    check_all("rst_req");

    // Randomized commands against the model (ID opcode excluded)
    base_send = n_send;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      data = $urandom;
      if (r <= 2)      code = 'h00;
      else if (r == 3) code = 'h01;
      else if (r == 4) code = ($urandom_range(0, 1) == 0) ? 'h11 : 'h13;
      else if (r == 5) code = 'h80 + int'($urandom_range(0, 2));
      else if (r <= 7) code = 'hC0 + int'($urandom_range(0, 15));
      else begin
        code = int'($urandom_range(0, 255));
        if (code == 'h02) code = 'h03;
      end
      if (r == 9) idle(1);
      else do_cmd(8'(code), data);
      check_all($sformatf("rand%0d", i));
    end
    chk("rand.no_send", n_send - base_send, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
- Sits directly downstream of the SPI command receiver and consumes its cmd_code/cmd_data/cmd_valid stream.
- Decodes SUMP short and long commands into the capture configuration register bank and control strobes (soft reset, arm, flow control).
- Answers the ID query (0x02) by issuing a 32-bit send request into the transmit stream through a send/busy handshake.
- Query commands 0x04 (metadata) and 0x06 (dataIn) are handled elsewhere and are ignored here.

Parameters:
- NUM_STAGES, 4, number of trigger stages; legal range 1..4.
- ID_WORD, 32'h534c4131, word returned for the ID query ("1ALS", LSB byte sent first).
- RESET_REPEAT, 5, number of consecutive 0x00 commands required to assert soft_reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_code  in  8  command opcode
- cmd_data  in  32  long-command payload
- cmd_valid  in  1  one-cycle command strobe
- busy  in  1  transmitter busy
- send  out  1  one-cycle send request
- send_data  out  32  word to transmit
- send_valid  out  4  byte-enable mask for send_data
- soft_reset  out  1  one-cycle core reset pulse
- arm  out  1  one-cycle arm pulse
- xoff  out  1  flow-control pause level
- divider  out  24  sample clock divider
- read_count  out  16  samples to read back
- delay_count  out  16  samples captured after trigger
- flags  out  16  capture flags
- trig_mask  out  32*NUM_STAGES  per-stage mask, stage s at [32s+31:32s]
- trig_value  out  32*NUM_STAGES  per-stage value
- trig_cfg  out  32*NUM_STAGES  per-stage configuration

Behaviour:
- Reset: a single clock; rst is synchronous and active-high. rst=1 at a clk edge clears every output and register to 0, including xoff, and the id FSM returns to IDLE. send_data and send_valid are also 0.
- Command latching: sampled only when cmd_valid=1; a register update is visible 1 cycle after the strobe. Pulses (arm, soft_reset) are high for exactly 1 cycle, 1 cycle after the strobe.
- Long commands:
  - 0x80: divider <= cmd_data[23:0].
  - 0x81: read_count <= cmd_data[15:0], delay_count <= cmd_data[31:16].
  - 0x82: flags <= cmd_data[15:0].
  - 0xC0+4s / 0xC1+4s / 0xC2+4s: write trig_mask / trig_value / trig_cfg of stage s.
  - Stage s >= NUM_STAGES is ignored. Code 0xC3+4s is ignored.
- Short commands:
  - 0x01: arm pulse.
  - 0x13: xoff <= 1.
  - 0x11: xoff <= 0.
  - 0x02: ID request.
- All other codes are ignored and change no state.
- Reset counter (3 bits):
  - Each cmd_valid with code 0x00 increments it. On reaching RESET_REPEAT it pulses soft_reset and clears to 0.
  - Any cmd_valid with a non-zero code clears it.
  - cycles without cmd_valid leave it unchanged.
- soft_reset also clears every configuration register and xoff to 0 on the same edge the pulse is driven. The id FSM is not affected.
- ID FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ on cmd 0x02.
  - REQ: when busy=0, drive send=1, send_data=ID_WORD, send_valid=4'hF for 1 cycle, then go to WAIT. While busy=1, hold in REQ with send=0.
  - WAIT -> IDLE on the first cycle busy=1, or after 4 cycles without busy (timeout counter).
  - 0x02 received while in REQ or WAIT is dropped; there is no queueing.
  - send_valid and send_data return to 0 when send=0.
- Simultaneous events: the cmd stream delivers at most one command per cycle, so there is no intra-stream collision. rst has priority over everything.

Decomposition:
- Package sump_pkg:
  - opcode constants: CMD_RESET=8'h00, CMD_ARM=8'h01, CMD_ID=8'h02, CMD_XON=8'h11, CMD_XOFF=8'h13, CMD_DIV=8'h80, CMD_CNT=8'h81, CMD_FLAGS=8'h82, CMD_TRIG_BASE=8'hC0.
  - ID word constant.
  - id FSM state enum.
- One natural sub-module: sump_id_responder, containing the ID FSM and the send/busy handshake.

Test Plan:
- Reset state: rst for 2 cycles -> all outputs 0, send=0.
- Long writes: cmd 0x80 data 32'h00123456 -> divider=24'h123456 the next cycle. Cmd 0x81 data 32'h0010_0200 -> read_count=16'h0200, delay_count=16'h0010. Cmd 0xC5 data 32'hDEADBEEF -> trig_value stage1=32'hDEADBEEF, other stages unchanged.
- Reset sequence:
  - five 0x00 commands -> single soft_reset pulse after the 5th, and a prior divider value returns to 0.
  - four 0x00, then 0x01, then four 0x00 -> no soft_reset; arm pulses once.
- ID with busy low: cmd 0x02 with busy=0 -> send=1 for 1 cycle with send_data=32'h534c4131, send_valid=4'hF.
- ID with busy held: hold busy=1 for 10 cycles after cmd 0x02 -> send stays 0, then asserts on the first busy=0 cycle. A second 0x02 while in REQ produces no extra send.
- Flow control and bounds: 0x13 -> xoff=1; 0x11 -> xoff=0. With NUM_STAGES=2, cmd 0xC8 -> no register changes. rst asserted while in REQ -> FSM returns to IDLE and no send is issued.
